// File: rtl/s526p_interval_seq.sv
// Round-robin interval sequencer: a W-bit slot counter steps through the enabled
// channels, emitting a tick per completed slot, in one-shot or periodic mode.
module s526p_interval_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 0
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic [W-1:0] PERIOD,
    input  logic [N-1:0] CH_EN,
    output logic         TICK,
    output logic [N-1:0] ACT,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] COUNT
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_prd;
    logic           r_mode;
    logic [N-1:0]   r_mask;
    logic [PW-1:0]  r_ptr;
    logic           r_tick_i;
    logic [N-1:0]   r_act_i;

    logic [PW-1:0]  w_first;
    logic [PW-1:0]  w_next;
    logic [N-1:0]   w_ptr_oh;
    logic           w_wrap;
    logic           w_accept;
    logic           w_term;

    // Descending scans so the lowest qualifying bit is the one left standing.
    always_comb begin
        w_first = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (CH_EN[i-1]) w_first = PW'(i - 1);
        end
    end

    always_comb begin
        w_next = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (r_mask[i-1]) w_next = PW'(i - 1);
        end
        for (int unsigned i = N; i > 0; i--) begin
            if (r_mask[i-1] && (PW'(i - 1) > r_ptr)) w_next = PW'(i - 1);
        end
    end

    always_comb begin
        w_ptr_oh        = '0;
        w_ptr_oh[r_ptr] = 1'b1;
    end

    assign w_wrap   = (w_next <= r_ptr);
    assign w_accept = START && (PERIOD != '0) && (CH_EN != '0);
    assign w_term   = (r_count == (r_prd - 1'b1));

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_prd    <= '0;
            r_mode   <= 1'b0;
            r_mask   <= '0;
            r_ptr    <= '0;
            r_tick_i <= 1'b0;
            r_act_i  <= '0;
        end else begin
            r_tick_i <= 1'b0;
            r_act_i  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_prd   <= PERIOD;
                        r_mode  <= MODE;
                        r_mask  <= CH_EN;
                        r_ptr   <= w_first;
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // An abort wins over a coinciding slot completion.
                    if (STOP) begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else if (w_term) begin
                        r_count  <= '0;
                        r_tick_i <= 1'b1;
                        r_act_i  <= w_ptr_oh;
                        r_ptr    <= w_next;
                        if (!r_mode && w_wrap) r_state <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY  = (r_state == S_RUN);
    assign DONE  = (r_state == S_DONE);
    assign COUNT = r_count;

    generate
        if (DEPTH == 0) begin : g_nopipe
            assign TICK = r_tick_i;
            assign ACT  = r_act_i;
        end else begin : g_pipe
            logic [DEPTH-1:0]        r_tick_pipe;
            logic [DEPTH-1:0][N-1:0] r_act_pipe;

            always_ff @(posedge CK or negedge RN) begin
                if (!RN) begin
                    r_tick_pipe <= '0;
                    r_act_pipe  <= '0;
                end else begin
                    r_tick_pipe[0] <= r_tick_i;
                    r_act_pipe[0]  <= r_act_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_tick_pipe[i] <= r_tick_pipe[i-1];
                        r_act_pipe[i]  <= r_act_pipe[i-1];
                    end
                end
            end

            assign TICK = r_tick_pipe[DEPTH-1];
            assign ACT  = r_act_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: tb/tb_s526p_interval_seq.sv
// Directed bench for s526p_interval_seq: DEPTH=0 and DEPTH=2 instances share stimulus
// and are compared every cycle against a slot-schedule model.
module tb_s526p_interval_seq;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       MODE = 1'b0;
    logic [7:0] PERIOD = '0;
    logic [3:0] CH_EN = '0;

    logic       t0, b0, d0, t2, b2, d2;
    logic [3:0] a0, a2;
    logic [7:0] c0, c2;

    int vectors = 0;
    int miscompares = 0;

    s526p_interval_seq #(.W(8), .N(4), .DEPTH(0)) dut0 (
        .CK(CK), .RN(RN), .START(START), .STOP(STOP), .MODE(MODE),
        .PERIOD(PERIOD), .CH_EN(CH_EN),
        .TICK(t0), .ACT(a0), .BUSY(b0), .DONE(d0), .COUNT(c0)
    );

    s526p_interval_seq #(.W(8), .N(4), .DEPTH(2)) dut2 (
        .CK(CK), .RN(RN), .START(START), .STOP(STOP), .MODE(MODE),
        .PERIOD(PERIOD), .CH_EN(CH_EN),
        .TICK(t2), .ACT(a2), .BUSY(b2), .DONE(d2), .COUNT(c2)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a run is a schedule of slots of m_prd cycles each, visiting the
    // enabled channel list in order; m_el is cycles elapsed in the current slot.
    bit         m_run = 0;
    bit         m_done = 0;
    int         m_el = 0;
    int         m_prd = 0;
    int         m_slots = 0;
    bit         m_mode = 0;
    int         m_ch[$];
    logic       mt;
    logic [3:0] ma;
    logic       m_tick_h[5] = '{default: 1'b0};
    logic [3:0] m_act_h[5] = '{default: 4'h0};

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_run = 0; m_done = 0; m_el = 0; m_prd = 0; m_slots = 0; m_mode = 0;
            m_ch.delete();
            for (int i = 0; i < 5; i++) begin
                m_tick_h[i] = 1'b0;
                m_act_h[i]  = 4'h0;
            end
        end else begin
            mt = 1'b0;
            ma = 4'h0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_run) begin
                if (START && PERIOD != 0 && CH_EN != 0) begin
                    m_run = 1; m_el = 0; m_prd = int'(PERIOD); m_mode = MODE; m_slots = 0;
                    m_ch.delete();
                    for (int i = 0; i < 4; i++) if (CH_EN[i]) m_ch.push_back(i);
                end
            end else if (STOP) begin
                m_run = 0;
                m_el = 0;
            end else begin
                m_el++;
                if (m_el == m_prd) begin
                    m_el = 0;
                    mt = 1'b1;
                    ma = 4'(1 << m_ch[m_slots % m_ch.size()]);
                    m_slots++;
                    if (!m_mode && m_slots == m_ch.size()) begin
                        m_run = 0;
                        m_done = 1;
                    end
                end
            end
            for (int i = 4; i > 0; i--) begin
                m_tick_h[i] = m_tick_h[i-1];
                m_act_h[i]  = m_act_h[i-1];
            end
            m_tick_h[0] = mt;
            m_act_h[0]  = ma;
        end
    end

    always @(posedge CK) begin
        #1;
        chk("m_tick0", {31'b0, t0}, {31'b0, m_tick_h[0]});
        chk("m_act0",  {28'b0, a0}, {28'b0, m_act_h[0]});
        chk("m_busy0", {31'b0, b0}, {31'b0, m_run});
        chk("m_done0", {31'b0, d0}, {31'b0, m_done});
        chk("m_count0", {24'b0, c0}, m_el);
        chk("m_tick2", {31'b0, t2}, {31'b0, m_tick_h[2]});
        chk("m_act2",  {28'b0, a2}, {28'b0, m_act_h[2]});
        chk("m_busy2", {31'b0, b2}, {31'b0, m_run});
        chk("m_done2", {31'b0, d2}, {31'b0, m_done});
        chk("m_count2", {24'b0, c2}, m_el);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CK);
    endtask

    // Drives START for exactly one edge; returns at the negedge after the accept edge.
    task automatic start_cfg(input logic [7:0] p, input logic m, input logic [3:0] mask);
        START = 1'b1; PERIOD = p; MODE = m; CH_EN = mask;
        @(negedge CK);
        START = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_tick0"}, {31'b0, t0}, 0);
        chk({tag, "_act0"}, {28'b0, a0}, 0);
        chk({tag, "_busy0"}, {31'b0, b0}, 0);
        chk({tag, "_done0"}, {31'b0, d0}, 0);
        chk({tag, "_count0"}, {24'b0, c0}, 0);
        chk({tag, "_tick2"}, {31'b0, t2}, 0);
        chk({tag, "_act2"}, {28'b0, a2}, 0);
        chk({tag, "_busy2"}, {31'b0, b2}, 0);
    endtask

    task automatic oneshot_seq(input string tag);
        start_cfg(8'd3, 1'b0, 4'b0101);
        chk({tag, "_busy_a0"}, {31'b0, b0}, 1);
        step(2);
        chk({tag, "_tick_a2"}, {31'b0, t0}, 0);
        step(1);
        chk({tag, "_tick_a3"}, {31'b0, t0}, 1);
        chk({tag, "_act_a3"}, {28'b0, a0}, 32'h1);
        chk({tag, "_busy_a3"}, {31'b0, b0}, 1);
        step(3);
        chk({tag, "_tick_a6"}, {31'b0, t0}, 1);
        chk({tag, "_act_a6"}, {28'b0, a0}, 32'h4);
        chk({tag, "_done_a6"}, {31'b0, d0}, 1);
        chk({tag, "_busy_a6"}, {31'b0, b0}, 0);
        step(1);
        chk({tag, "_done_a7"}, {31'b0, d0}, 0);
        chk({tag, "_busy_a7"}, {31'b0, b0}, 0);
    endtask

    initial begin
        #2;
        all_zero("reset");
        step(2);
        RN = 1'b1;
        step(1);

        oneshot_seq("t1");
        step(2);

        start_cfg(8'd2, 1'b1, 4'b1001);
        step(2);
        chk("t2_act1", {28'b0, a0}, 32'h1);
        step(2);
        chk("t2_act2", {28'b0, a0}, 32'h8);
        step(2);
        chk("t2_act3", {28'b0, a0}, 32'h1);
        step(2);
        chk("t2_act4", {28'b0, a0}, 32'h8);
        chk("t2_busy4", {31'b0, b0}, 1);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("t2_busy_stop", {31'b0, b0}, 0);
        chk("t2_done_stop", {31'b0, d0}, 0);
        step(2);
        chk("t2_done_after", {31'b0, d0}, 0);

        start_cfg(8'd4, 1'b0, 4'b0001);
        step(3);
        chk("t3_count", {24'b0, c0}, 3);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("t3_tick", {31'b0, t0}, 0);
        chk("t3_busy", {31'b0, b0}, 0);
        chk("t3_done", {31'b0, d0}, 0);
        chk("t3_count0", {24'b0, c0}, 0);
        step(1);
        chk("t3_done_next", {31'b0, d0}, 0);

        START = 1'b1; PERIOD = 8'd0; CH_EN = 4'b1111; MODE = 1'b0;
        step(1);
        chk("t4_busy_p0", {31'b0, b0}, 0);
        PERIOD = 8'd5; CH_EN = 4'b0000;
        step(1);
        chk("t4_busy_m0", {31'b0, b0}, 0);
        chk("t4_count", {24'b0, c0}, 0);
        START = 1'b0;
        step(2);
        chk("t4_tick", {31'b0, t0}, 0);
        chk("t4_done", {31'b0, d0}, 0);

        start_cfg(8'd1, 1'b1, 4'b0010);
        chk("t5_tick2_a0", {31'b0, t2}, 0);
        step(1);
        chk("t5_tick0_a1", {31'b0, t0}, 1);
        chk("t5_act0_a1", {28'b0, a0}, 32'h2);
        chk("t5_tick2_a1", {31'b0, t2}, 0);
        step(1);
        chk("t5_tick2_a2", {31'b0, t2}, 0);
        step(1);
        chk("t5_tick2_a3", {31'b0, t2}, 1);
        chk("t5_act2_a3", {28'b0, a2}, 32'h2);
        step(3);
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
        chk("t5_busy_stop", {31'b0, b2}, 0);
        chk("t5_tick0_stop", {31'b0, t0}, 0);
        chk("t5_tick2_drain1", {31'b0, t2}, 1);
        step(1);
        chk("t5_tick2_drain2", {31'b0, t2}, 1);
        step(1);
        chk("t5_tick2_end", {31'b0, t2}, 0);
        chk("t5_act2_end", {28'b0, a2}, 0);
        step(2);

        start_cfg(8'd3, 1'b0, 4'b0101);
        step(1);
        chk("t6_busy_pre", {31'b0, b0}, 1);
        #2;
        RN = 1'b0;
        #1;
        all_zero("t6_async");
        @(negedge CK);
        all_zero("t6_held");
        RN = 1'b1;
        step(1);
        oneshot_seq("t6");
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
